// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 3-digit
// time-multiplexed display bus with optional leading-zero blanking.
module bcd_scan_driver #(
  parameter int SCAN_DIV = 1024,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  output logic [3:0] digit,
  output logic [2:0] digit_en,
  output logic       blank,
  output logic       busy
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      last_q, last_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [11:0]     bcd_q, bcd_d;
  logic [2:0]      iter_q, iter_d;
  logic [3:0]      h_q, h_d, t_q, t_d, o_q, o_d;
  logic [1:0]      idx_q, idx_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [11:0]     adj;
  logic            wrap;
  logic            blank_h, blank_t;

  // State register: conversion FSM, datapath and scan counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= '0;
      shreg_q <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      h_q     <= '0;
      t_q     <= '0;
      o_q     <= '0;
      idx_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      h_q     <= h_d;
      t_q     <= t_d;
      o_q     <= o_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
    end
  end

  // Add-3 correction on every nibble that would overflow past 9 after doubling.
  always_comb begin
    adj[3:0]  = (bcd_q[3:0]  >= 4'd5) ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
    adj[7:4]  = (bcd_q[7:4]  >= 4'd5) ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
    adj[11:8] = (bcd_q[11:8] >= 4'd5) ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];
  end

  // Next-state and datapath; value is only sampled in IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    h_d     = h_q;
    t_d     = t_q;
    o_d     = o_q;
    case (state_q)
      IDLE: begin
        if (value != last_q) begin
          shreg_d = value;
          last_d  = value;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d   = {adj[10:0], shreg_q[7]};
        shreg_d = {shreg_q[6:0], 1'b0};
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = LOAD;
      end
      LOAD: begin
        h_d     = bcd_q[11:8];
        t_d     = bcd_q[7:4];
        o_d     = bcd_q[3:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running digit scan, independent of conversion.
  always_comb begin
    wrap    = (presc_q == PRESC_LAST);
    presc_d = wrap ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (idx_q == 2'd3) idx_d = 2'd0;
    else if (wrap)     idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
  end

  // Outputs derive only from registered state.
  always_comb begin
    busy     = (state_q != IDLE);
    blank_h  = BLANK_LZ && (h_q == 4'd0);
    blank_t  = BLANK_LZ && (h_q == 4'd0) && (t_q == 4'd0);
    digit    = o_q;
    digit_en = 3'b001;
    blank    = 1'b0;
    case (idx_q)
      2'd1: begin
        if (blank_t) begin
          digit    = 4'd0;
          digit_en = 3'b000;
          blank    = 1'b1;
        end else begin
          digit    = t_q;
          digit_en = 3'b010;
        end
      end
      2'd2: begin
        if (blank_h) begin
          digit    = 4'd0;
          digit_en = 3'b000;
          blank    = 1'b1;
        end else begin
          digit    = h_q;
          digit_en = 3'b100;
        end
      end
      default: begin
        digit    = o_q;
        digit_en = 3'b001;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Bench for bcd_scan_driver: two instances (blanking on/off) against a
// decimal-arithmetic reference of the display and conversion latency.
module tb_bcd_scan_driver;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = 8'd0;

  logic [3:0] dig_b, dig_n;
  logic [2:0] en_b, en_n;
  logic       blk_b, blk_n, busy_b, busy_n;

  int checks = 0;
  int errors = 0;

  // Reference: edges since reset, conversion countdown, shown value.
  int m_k = 0, m_cnt = 0, m_last = 0, m_pend = 0, m_disp = 0;
  logic [7:0] exp_q[$];

  bcd_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .value(value),
    .digit(dig_b), .digit_en(en_b), .blank(blk_b), .busy(busy_b)
  );

  bcd_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .value(value),
    .digit(dig_n), .digit_en(en_n), .blank(blk_n), .busy(busy_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_cnt = 0; m_last = 0; m_pend = 0; m_disp = 0;
    end else begin
      m_k++;
      if (m_cnt == 0) begin
        if (int'(value) != m_last) begin
          m_last = int'(value);
          m_pend = int'(value);
          m_cnt  = 9;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) m_disp = m_pend;
      end
    end
  end

  // Expected {busy, blank, digit_en, digit} for the current cycle.
  function automatic logic [8:0] exp_vec(input bit blz);
    int idx, h, t, o;
    logic [3:0] d;
    logic [2:0] en;
    logic b;
    idx = (m_k / SCAN_DIV) % 3;
    h = m_disp / 100;
    t = (m_disp / 10) % 10;
    o = m_disp % 10;
    d = 4'(o); en = 3'b001; b = 1'b0;
    if (idx == 1) begin
      if (blz && h == 0 && t == 0) begin d = 4'd0; en = 3'b000; b = 1'b1; end
      else begin d = 4'(t); en = 3'b010; end
    end else if (idx == 2) begin
      if (blz && h == 0) begin d = 4'd0; en = 3'b000; b = 1'b1; end
      else begin d = 4'(h); en = 3'b100; end
    end
    return {m_cnt != 0, b, en, d};
  endfunction

  // Observes one full scan period on the unblanked instance.
  task automatic read_display(output int h, output int t, output int o);
    h = -1; t = -1; o = -1;
    repeat (3 * SCAN_DIV) begin
      @(negedge clk);
      if (en_n == 3'b001) o = int'(dig_n);
      if (en_n == 3'b010) t = int'(dig_n);
      if (en_n == 3'b100) h = int'(dig_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    value = 8'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_b, blk_b, en_b, dig_b} !== 9'b0_0_001_0000) begin
      errors++; $display("FAIL reset_vals got %b exp %b", {busy_b, blk_b, en_b, dig_b}, 9'b0_0_001_0000);
    end
    rst_n = 1'b1;
    repeat (24) begin
      @(negedge clk);
      checks++;
      if ({busy_b, blk_b, en_b, dig_b} !== exp_vec(1'b1)) begin
        errors++; $display("FAIL reset_scan_lz1 k=%0d got %b exp %b", m_k, {busy_b, blk_b, en_b, dig_b}, exp_vec(1'b1));
      end
      checks++;
      if ({busy_n, blk_n, en_n, dig_n} !== exp_vec(1'b0)) begin
        errors++; $display("FAIL reset_scan_lz0 k=%0d got %b exp %b", m_k, {busy_n, blk_n, en_n, dig_n}, exp_vec(1'b0));
      end
    end
  endtask

  task automatic test_full_scale();
    int nbusy, h, t, o;
    nbusy = 0;
    value = 8'd255;
    repeat (30) begin
      @(negedge clk);
      if (busy_b) nbusy++;
      checks++;
      if ({busy_b, blk_b, en_b, dig_b} !== exp_vec(1'b1)) begin
        errors++; $display("FAIL full_scale k=%0d got %b exp %b", m_k, {busy_b, blk_b, en_b, dig_b}, exp_vec(1'b1));
      end
    end
    checks++;
    if (nbusy != 9) begin
      errors++; $display("FAIL busy_len got %0d exp 9", nbusy);
    end
    read_display(h, t, o);
    checks++;
    if (h != 2 || t != 5 || o != 5) begin
      errors++; $display("FAIL disp_255 got %0d/%0d/%0d exp 2/5/5", h, t, o);
    end
  endtask

  task automatic test_pattern(input logic [7:0] v, input int eh, input int et, input int eo);
    int h, t, o;
    value = v;
    repeat (24) begin
      @(negedge clk);
      checks++;
      if ({busy_b, blk_b, en_b, dig_b} !== exp_vec(1'b1)) begin
        errors++; $display("FAIL pattern_lz1 v=%0d k=%0d got %b exp %b", v, m_k, {busy_b, blk_b, en_b, dig_b}, exp_vec(1'b1));
      end
      checks++;
      if ({busy_n, blk_n, en_n, dig_n} !== exp_vec(1'b0)) begin
        errors++; $display("FAIL pattern_lz0 v=%0d k=%0d got %b exp %b", v, m_k, {busy_n, blk_n, en_n, dig_n}, exp_vec(1'b0));
      end
    end
    read_display(h, t, o);
    checks++;
    if (h != eh || t != et || o != eo) begin
      errors++; $display("FAIL disp_v%0d got %0d/%0d/%0d exp %0d/%0d/%0d", v, h, t, o, eh, et, eo);
    end
  endtask

  task automatic test_back_to_back();
    int h, t, o;
    logic [7:0] e;
    value = 8'd200;
    exp_q.push_back(8'd200);
    @(negedge clk);
    repeat (3) @(negedge clk);
    value = 8'd42;
    exp_q.push_back(8'd42);
    repeat (40) begin
      @(negedge clk);
      checks++;
      if ({busy_b, blk_b, en_b, dig_b} !== exp_vec(1'b1)) begin
        errors++; $display("FAIL b2b_lz1 k=%0d got %b exp %b", m_k, {busy_b, blk_b, en_b, dig_b}, exp_vec(1'b1));
      end
      checks++;
      if ({busy_n, blk_n, en_n, dig_n} !== exp_vec(1'b0)) begin
        errors++; $display("FAIL b2b_lz0 k=%0d got %b exp %b", m_k, {busy_n, blk_n, en_n, dig_n}, exp_vec(1'b0));
      end
    end
    read_display(h, t, o);
    e = exp_q.pop_back();
    exp_q.delete();
    checks++;
    if (h * 100 + t * 10 + o != int'(e)) begin
      errors++; $display("FAIL b2b_final got %0d/%0d/%0d exp %0d", h, t, o, e);
    end
  endtask

  task automatic test_reset_mid();
    int h, t, o;
    value = 8'd99;
    repeat (4) @(negedge clk);
    checks++;
    if (busy_b !== 1'b1) begin
      errors++; $display("FAIL mid_busy got %b exp 1", busy_b);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_b, en_b, dig_b} !== 8'b0_001_0000) begin
      errors++; $display("FAIL async_rst_lz1 got %b exp %b", {busy_b, en_b, dig_b}, 8'b0_001_0000);
    end
    checks++;
    if ({busy_n, en_n, dig_n} !== 8'b0_001_0000) begin
      errors++; $display("FAIL async_rst_lz0 got %b exp %b", {busy_n, en_n, dig_n}, 8'b0_001_0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      checks++;
      if ({busy_b, blk_b, en_b, dig_b} !== exp_vec(1'b1)) begin
        errors++; $display("FAIL rst_mid_lz1 k=%0d got %b exp %b", m_k, {busy_b, blk_b, en_b, dig_b}, exp_vec(1'b1));
      end
    end
    read_display(h, t, o);
    checks++;
    if (h != 0 || t != 9 || o != 9) begin
      errors++; $display("FAIL disp_99 got %0d/%0d/%0d exp 0/9/9", h, t, o);
    end
  endtask

  task automatic test_random();
    int h, t, o;
    logic [7:0] v, e;
    for (int i = 0; i < 25; i++) begin
      v = 8'($urandom_range(0, 255));
      value = v;
      exp_q.push_back(v);
      repeat ($urandom_range(1, 14)) begin
        @(negedge clk);
        checks++;
        if ({busy_b, blk_b, en_b, dig_b} !== exp_vec(1'b1)) begin
          errors++; $display("FAIL rand_lz1 k=%0d got %b exp %b", m_k, {busy_b, blk_b, en_b, dig_b}, exp_vec(1'b1));
        end
        checks++;
        if ({busy_n, blk_n, en_n, dig_n} !== exp_vec(1'b0)) begin
          errors++; $display("FAIL rand_lz0 k=%0d got %b exp %b", m_k, {busy_n, blk_n, en_n, dig_n}, exp_vec(1'b0));
        end
      end
    end
    repeat (24) @(negedge clk);
    read_display(h, t, o);
    e = exp_q.pop_back();
    checks++;
    if (h * 100 + t * 10 + o != int'(e)) begin
      errors++; $display("FAIL rand_final got %0d/%0d/%0d exp %0d", h, t, o, e);
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_pattern(8'd7, 0, 0, 7);
    test_pattern(8'd105, 1, 0, 5);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
